square_move_scheduler: RTL



---
 rtl/square_move_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/square_move_scheduler.sv
// Move-strobe sequencer for bouncing-square sprites: finds the start of vertical blanking,
// divides frames and issues one strobe per enabled square, lowest index first, GAP idle cycles apart.
module square_move_scheduler #(
    parameter int N_SQUARES = 3,
    parameter int V_ACTIVE  = 480,
    parameter int FRAME_DIV = 1,
    parameter int GAP       = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic [N_SQUARES-1:0] ENABLE_MASK,
    input  logic                 PAUSE,
    input  logic                 STEP,
    input  logic                 CLR_OVERRUN,
    output logic [N_SQUARES-1:0] MOVE_STB,
    output logic                 BUSY,
    output logic                 OVERRUN,
    output logic [15:0]          FRAME_CNT
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

    localparam logic [9:0] V_LIM    = 10'(V_ACTIVE);
    localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [3:0]             gap_q, gap_d;
    logic [N_SQUARES-1:0]   mask_q, mask_d;
    logic                   in_vb_q;
    logic [3:0]             div_cnt;

    logic in_vb, vb_rise, frame_trig, step_trig, seq_active, overrun_set, start;
    logic [3:0] first_set, next_set;

    // Column is not needed for scheduling; it is folded away here.
    logic unused_x;
    assign unused_x = ^x;

    // Returns {found, index} of the lowest set bit of m at or above position start.
    function automatic logic [3:0] find_from(input logic [N_SQUARES-1:0] m, input int start_pos);
        logic [3:0] r;
        r = '0;
        for (int i = N_SQUARES - 1; i >= 0; i--) begin
            if (i >= start_pos && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign in_vb       = (y >= V_LIM);
    assign vb_rise     = in_vb & ~in_vb_q;
    assign frame_trig  = vb_rise & ~PAUSE & (div_cnt == DIV_LAST);
    // Covers the cycle after the FSM returns to IDLE while BUSY is still registered high.
    assign seq_active  = BUSY | (state_q != IDLE);
    assign step_trig   = STEP & PAUSE & (state_q == IDLE);
    assign overrun_set = frame_trig & seq_active;
    assign start       = (frame_trig & ~seq_active) | step_trig;
    assign first_set   = find_from(ENABLE_MASK, 0);
    assign next_set    = find_from(mask_q, int'(idx_q) + 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = ENABLE_MASK;
                    if (first_set[3]) begin
                        state_d = STROBE;
                        idx_d   = first_set[2:0];
                    end
                end
            end
            STROBE: begin
                gap_d = '0;
                if (GAP > 0) begin
                    state_d = WAIT;
                end else if (next_set[3]) begin
                    idx_d = next_set[2:0];
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (gap_q == GAP_LAST) begin
                    if (next_set[3]) begin
                        state_d = STROBE;
                        idx_d   = next_set[2:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            mask_q    <= '0;
            in_vb_q   <= 1'b1;
            div_cnt   <= '0;
            FRAME_CNT <= '0;
            MOVE_STB  <= '0;
            BUSY      <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            mask_q  <= mask_d;
            in_vb_q <= in_vb;
            if (vb_rise && !PAUSE) begin
                div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            end
            FRAME_CNT <= FRAME_CNT + 16'(vb_rise);
            // Outputs lag the FSM by one cycle so every output comes straight from a flop.
            MOVE_STB  <= (state_q == STROBE) ? (N_SQUARES'(1) << idx_q) : '0;
            BUSY      <= (state_q != IDLE);
            OVERRUN   <= overrun_set | (OVERRUN & ~CLR_OVERRUN);
        end
    end

endmodule
